// File: rtl/tmds_pkg.sv
// Shared TMDS types, fixed code words and the TERC4 table for the HDMI channel encoder.
package tmds_pkg;

   typedef enum logic [2:0] {
      CTRL      = 3'd0,
      VIDEO     = 3'd1,
      VIDEO_GB  = 3'd2,
      ISLAND    = 3'd3,
      ISLAND_GB = 3'd4
   } tmds_mode_e;

   // Indexed by {C1,C0}.
   localparam logic [3:0][9:0] CTRL_CODE = {
      10'b1010101011, 10'b0101010100, 10'b0010101011, 10'b1101010100
   };

   localparam logic [9:0] GB_VIDEO_02  = 10'b1011001100;
   localparam logic [9:0] GB_VIDEO_1   = 10'b0100110011;
   localparam logic [9:0] GB_ISLAND_12 = 10'b0100110011;

   typedef struct packed {
      logic [8:0] qm;
      logic [4:0] diff;   // N1-N0 of qm[7:0], two's complement
      logic [2:0] mode;
      logic [1:0] cd;
      logic [3:0] aux;
   } qm_stage_t;

   function automatic logic [9:0] terc4(input logic [3:0] d);
      logic [9:0] s;
      case (d)
         4'h0: s = 10'b1010011100;
         4'h1: s = 10'b1001100011;
         4'h2: s = 10'b1011100100;
         4'h3: s = 10'b1011100010;
         4'h4: s = 10'b0101110001;
         4'h5: s = 10'b0100011110;
         4'h6: s = 10'b0110001110;
         4'h7: s = 10'b0100111100;
         4'h8: s = 10'b1011001100;
         4'h9: s = 10'b0100111001;
         4'hA: s = 10'b0110011100;
         4'hB: s = 10'b1011000110;
         4'hC: s = 10'b1010001110;
         4'hD: s = 10'b1001110001;
         4'hE: s = 10'b0101100011;
         default: s = 10'b1011000011;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/tmds_qm_stage.sv
// Transition-minimising first half of the DVI video encode: pixel -> q_m[8:0] and N1-N0.
module tmds_qm_stage (
   input  logic        [7:0] vd,
   output logic        [8:0] qm,
   output logic signed [4:0] diff
);

   logic [3:0] n1;
   logic [3:0] nq;
   logic       use_xnor;

   always_comb begin
      n1       = 4'($countones(vd));
      use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !vd[0]);
      qm[0]    = vd[0];
      for (int i = 1; i < 8; i++)
         qm[i] = use_xnor ? ~(qm[i-1] ^ vd[i]) : (qm[i-1] ^ vd[i]);
      qm[8]    = ~use_xnor;
      nq       = 4'($countones(qm[7:0]));
      diff     = $signed({nq, 1'b0} - 5'd8);
   end

endmodule

// File: rtl/tmds_hdmi_encoder.sv
// Per-channel HDMI TMDS encoder: control, DC-balanced video, guard bands and TERC4 islands.
module tmds_hdmi_encoder
   import tmds_pkg::*;
#(
   parameter int CHANNEL     = 0,
   parameter int PIPE_STAGES = 1,
   parameter int DISP_W      = 5
) (
   input  logic                     clk,
   input  logic                     rstn_i,
   input  logic              [2:0]  mode_i,
   input  logic              [7:0]  vd_i,
   input  logic              [1:0]  cd_i,
   input  logic              [3:0]  aux_i,
   output logic              [9:0]  tmds_o,
   output logic signed [DISP_W-1:0] disp_o,
   output logic                     mode_err_o
);

   localparam logic signed [DISP_W-1:0] TWO = DISP_W'(2);

   logic        [8:0] qm_c;
   logic signed [4:0] diff_c;
   qm_stage_t         st_c, st;

   tmds_qm_stage u_qm (.vd(vd_i), .qm(qm_c), .diff(diff_c));

   assign st_c = '{qm: qm_c, diff: diff_c, mode: mode_i, cd: cd_i, aux: aux_i};

   generate
      if (PIPE_STAGES == 2) begin : g_pipe2
         always_ff @(posedge clk or negedge rstn_i)
            if (!rstn_i) st <= '0;
            else         st <= st_c;
      end else begin : g_pipe1
         assign st = st_c;
      end
   endgenerate

   logic signed [DISP_W-1:0] d, cnt_nx;
   logic              [9:0]  sym_nx;
   logic                     err_nx, q8;

   // disp_o doubles as the running-disparity register seen by the next symbol.
   always_comb begin
      d      = DISP_W'($signed(st.diff));
      q8     = st.qm[8];
      sym_nx = CTRL_CODE[st.cd];
      cnt_nx = '0;
      err_nx = 1'b0;
      case (st.mode)
         CTRL: ;
         VIDEO: begin
            if (disp_o == 0 || d == 0) begin
               sym_nx = {~q8, q8, q8 ? st.qm[7:0] : ~st.qm[7:0]};
               cnt_nx = q8 ? disp_o + d : disp_o - d;
            end else if ((disp_o > 0 && d > 0) || (disp_o < 0 && d < 0)) begin
               sym_nx = {1'b1, q8, ~st.qm[7:0]};
               cnt_nx = disp_o - d;
               if (q8) cnt_nx = cnt_nx + TWO;
            end else begin
               sym_nx = {1'b0, q8, st.qm[7:0]};
               cnt_nx = disp_o + d;
               if (!q8) cnt_nx = cnt_nx - TWO;
            end
         end
         VIDEO_GB:  sym_nx = (CHANNEL == 1) ? GB_VIDEO_1 : GB_VIDEO_02;
         ISLAND:    sym_nx = terc4(st.aux);
         ISLAND_GB: sym_nx = (CHANNEL == 0) ? terc4({2'b11, st.cd}) : GB_ISLAND_12;
         default:   err_nx = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         tmds_o     <= '0;
         disp_o     <= '0;
         mode_err_o <= 1'b0;
      end else begin
         tmds_o     <= sym_nx;
         disp_o     <= cnt_nx;
         mode_err_o <= err_nx;
      end
   end

endmodule

// File: tb/tb_tmds_hdmi_encoder.sv
// Scoreboard bench: three encoders (ch0/P1, ch1/P2, ch2/P1) on shared stimulus vs a symbol-level model.
module tb_tmds_hdmi_encoder;

   logic       clk = 1'b0;
   logic       rstn_i = 1'b0;
   logic [2:0] mode_i = '0;
   logic [7:0] vd_i = '0;
   logic [1:0] cd_i = '0;
   logic [3:0] aux_i = '0;

   logic        [9:0] tmds_a, tmds_b, tmds_c;
   logic signed [4:0] disp_a, disp_b, disp_c;
   logic              err_a, err_b, err_c;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      logic [9:0] sym;
      int         disp;
      logic       err;
   } exp_t;

   exp_t qa[$], qb[$], qc[$];
   int   cnt_m = 0;
   logic issued = 1'b0;
   logic [1:0] tag;

   logic [9:0] ctrl_tbl [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
   logic [9:0] terc_tbl [16] = '{
      10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
      10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
      10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
      10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

   always #5 clk = ~clk;

   tmds_hdmi_encoder #(.CHANNEL(0), .PIPE_STAGES(1), .DISP_W(5)) dut_a (
      .clk(clk), .rstn_i(rstn_i), .mode_i(mode_i), .vd_i(vd_i), .cd_i(cd_i), .aux_i(aux_i),
      .tmds_o(tmds_a), .disp_o(disp_a), .mode_err_o(err_a));
   tmds_hdmi_encoder #(.CHANNEL(1), .PIPE_STAGES(2), .DISP_W(5)) dut_b (
      .clk(clk), .rstn_i(rstn_i), .mode_i(mode_i), .vd_i(vd_i), .cd_i(cd_i), .aux_i(aux_i),
      .tmds_o(tmds_b), .disp_o(disp_b), .mode_err_o(err_b));
   tmds_hdmi_encoder #(.CHANNEL(2), .PIPE_STAGES(1), .DISP_W(5)) dut_c (
      .clk(clk), .rstn_i(rstn_i), .mode_i(mode_i), .vd_i(vd_i), .cd_i(cd_i), .aux_i(aux_i),
      .tmds_o(tmds_c), .disp_o(disp_c), .mode_err_o(err_c));

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
      end
   endtask

   // Pick the symbol polarity from the DVI rules, then derive disparity from the symbol itself.
   function automatic logic [9:0] enc_video(input logic [7:0] v, input int cnt);
      logic [7:0] q;
      logic       xn, inv;
      int         n1, dq;
      n1   = $countones(v);
      xn   = (n1 > 4) || (n1 == 4 && !v[0]);
      q[0] = v[0];
      for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ v[i]) : (q[i-1] ^ v[i]);
      dq = 2 * $countones(q) - 8;
      if (cnt == 0 || dq == 0) inv = xn;
      else if ((cnt > 0 && dq > 0) || (cnt < 0 && dq < 0)) inv = 1'b1;
      else inv = 1'b0;
      return {inv, ~xn, inv ? ~q : q};
   endfunction

   function automatic exp_t model(input int ch, input logic [2:0] m, input logic [7:0] v,
                                  input logic [1:0] c, input logic [3:0] a, input int cnt);
      exp_t e;
      e.disp = 0;
      e.err  = 1'b0;
      case (m)
         3'd0: e.sym = ctrl_tbl[c];
         3'd1: begin
            e.sym  = enc_video(v, cnt);
            e.disp = cnt + 2 * $countones(e.sym) - 10;
         end
         3'd2: e.sym = (ch == 1) ? 10'b0100110011 : 10'b1011001100;
         3'd3: e.sym = terc_tbl[a];
         3'd4: e.sym = (ch == 0) ? terc_tbl[{2'b11, c}] : 10'b0100110011;
         default: begin
            e.sym = ctrl_tbl[c];
            e.err = 1'b1;
         end
      endcase
      return e;
   endfunction

   task automatic issue(input logic [2:0] m, input logic [7:0] v, input logic [1:0] c, input logic [3:0] a);
      exp_t ea, eb, ec;
      @(posedge clk);
      #1;
      mode_i = m; vd_i = v; cd_i = c; aux_i = a;
      issued = 1'b1;
      ea = model(0, m, v, c, a, cnt_m);
      eb = model(1, m, v, c, a, cnt_m);
      ec = model(2, m, v, c, a, cnt_m);
      qa.push_back(ea); qb.push_back(eb); qc.push_back(ec);
      cnt_m = ea.disp;
   endtask

   task automatic cmp(input string nm, input exp_t e, input logic [9:0] s, input int d, input logic er);
      chk({nm, "_tmds"}, int'(s), int'(e.sym));
      chk({nm, "_disp"}, d, e.disp);
      chk({nm, "_err"}, int'(er), int'(e.err));
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_tmds_a"}, int'(tmds_a), 0);
      chk({nm, "_tmds_b"}, int'(tmds_b), 0);
      chk({nm, "_tmds_c"}, int'(tmds_c), 0);
      chk({nm, "_disp_a"}, int'(disp_a), 0);
      chk({nm, "_disp_b"}, int'(disp_b), 0);
      chk({nm, "_err_b"}, int'(err_b), 0);
   endtask

   // Tracks which output cycles carry an issued vector: bit0 for latency 1, bit1 for latency 2.
   always @(posedge clk or negedge rstn_i)
      if (!rstn_i) tag <= '0;
      else         tag <= {tag[0], issued};

   always @(negedge clk) begin
      exp_t e;
      if (rstn_i) begin
         if (tag[0]) begin
            if (qa.size() == 0) chk("a_queue_nonempty", 0, 1);
            else begin e = qa.pop_front(); cmp("a", e, tmds_a, int'(disp_a), err_a); end
            if (qc.size() == 0) chk("c_queue_nonempty", 0, 1);
            else begin e = qc.pop_front(); cmp("c", e, tmds_c, int'(disp_c), err_c); end
         end
         if (tag[1]) begin
            if (qb.size() == 0) chk("b_queue_nonempty", 0, 1);
            else begin e = qb.pop_front(); cmp("b", e, tmds_b, int'(disp_b), err_b); end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] m;
      int         r;
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      @(negedge clk);
      rstn_i = 1'b1;

      issue(3'd1, 8'h00, 2'b00, 4'h0);
      issue(3'd1, 8'h00, 2'b00, 4'h0);
      issue(3'd1, 8'hA5, 2'b00, 4'h0);
      issue(3'd0, 8'h00, 2'b11, 4'h0);
      issue(3'd2, 8'h00, 2'b00, 4'h0);
      issue(3'd3, 8'h00, 2'b00, 4'h0);
      issue(3'd3, 8'h00, 2'b00, 4'hF);
      issue(3'd4, 8'h00, 2'b01, 4'h0);
      issue(3'd7, 8'h00, 2'b00, 4'h0);
      issue(3'd0, 8'h00, 2'b00, 4'h0);
      issue(3'd1, 8'hFF, 2'b00, 4'h0);
      issue(3'd1, 8'h10, 2'b00, 4'h0);
      issue(3'd1, 8'h00, 2'b00, 4'h0);
      issue(3'd1, 8'h00, 2'b00, 4'h0);

      // Mid-stream asynchronous reset, away from any clock edge.
      #3;
      rstn_i = 1'b0;
      issued = 1'b0;
      qa.delete(); qb.delete(); qc.delete();
      cnt_m = 0;
      mode_i = 3'd0;
      #1;
      chk_zero("async_reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn_i = 1'b1;
      issue(3'd1, 8'h00, 2'b00, 4'h0);
      issue(3'd1, 8'h00, 2'b00, 4'h0);

      for (int k = 0; k < 500; k++) begin
         r = $urandom_range(0, 15);
         if (r <= 8)       m = 3'd1;
         else if (r <= 12) m = 3'(r - 9 + (r >= 10 ? 1 : 0));
         else              m = 3'($urandom_range(5, 7));
         issue(m, 8'($urandom), 2'($urandom), 4'($urandom));
      end

      @(posedge clk);
      #1;
      issued = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("qa_drained", qa.size(), 0);
      chk("qb_drained", qb.size(), 0);
      chk("qc_drained", qc.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/tmds_hdmi_encoder.md
Name: tmds_hdmi_encoder

Overview:
Per-channel HDMI-capable TMDS encoder. It is the parametrised successor of the DVI-only encoder and adds the following:
- video guard bands
- TERC4 data-island encoding and data-island guard bands
- channel-specific guard codes
- a configurable pipeline depth
- an exposed running disparity

Three instances (CHANNEL=0/1/2, i.e. blue/green/red) sit between the video timing/packet scheduler and the 10:1 serialisers.

Parameters:
- CHANNEL, 0, TMDS channel index 0..2; selects guard-band codes.
- PIPE_STAGES, 1, input-to-tmds_o latency in cycles; legal values 1 or 2.
- DISP_W, 5, width of the signed running-disparity register; must be >= 5.

Ports:
- clk  in  1  pixel clock
- rstn_i  in  1  asynchronous active-low reset
- mode_i  in  3  period mode, tmds_mode_e
- vd_i  in  8  video pixel component
- cd_i  in  2  control bits {C1,C0}; also the guard-band header bits in ISLAND_GB
- aux_i  in  4  TERC4 data-island nibble
- tmds_o  out  10  encoded symbol; bit 0 transmitted first
- disp_o  out  DISP_W  signed running disparity after the current tmds_o symbol
- mode_err_o  out  1  high for one cycle, aligned with tmds_o, when a reserved mode was encoded

Behaviour:
Interface and reset:
- One clock, clk. Reset rstn_i is asynchronous and active-low.
- Reset values: tmds_o=10'b0, disp_o=0, mode_err_o=0, and all pipeline registers 0.
- Reset asserted mid-stream clears everything immediately, including in-flight stages.

Modes (tmds_mode_e):
- CTRL=0: output the control code for cd_i.
  - 00 -> 1101010100
  - 01 -> 0010101011
  - 10 -> 0101010100
  - 11 -> 1010101011
- VIDEO=1: 8b/10b TMDS encoding with DC balance (see Video encoding).
- VIDEO_GB=2: CHANNEL 0 and 2 output 1011001100; CHANNEL 1 outputs 0100110011.
- ISLAND=3: output TERC4(aux_i).
- ISLAND_GB=4: CHANNEL 0 outputs TERC4({2'b11, cd_i}); CHANNEL 1 and 2 output 0100110011.
- 5..7 (reserved): output the CTRL code for cd_i and raise mode_err_o.

Video encoding (DVI 1.0 algorithm):
- n1 = ones(vd_i). Use XNOR when n1>4, or when n1==4 and vd_i[0]==0; otherwise use XOR.
- q_m[0] = vd_i[0]; q_m[i] = q_m[i-1] XOR/XNOR vd_i[i]; q_m[8] = ~XNOR.
- N1 and N0 are the ones and zeros counts of q_m[7:0]. cnt is the disparity register.
- Case A, cnt==0 or N1==N0:
  - out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}
  - cnt += q_m[8] ? N1-N0 : N0-N1
- Case B, (cnt>0 and N1>N0) or (cnt<0 and N0>N1):
  - out = {1, q_m[8], ~q_m[7:0]}
  - cnt += 2*q_m[8] + N0-N1
- Case C, otherwise:
  - out = {0, q_m[8], q_m[7:0]}
  - cnt += N1-N0 - 2*~q_m[8]
- All disparity arithmetic is signed DISP_W and never saturates; the DVI bound keeps |cnt| <= 10.

Disparity register:
- Updated only in VIDEO.
- Every non-VIDEO mode, reserved modes included, loads cnt=0. The first pixel after any guard band or control period therefore starts from 0.

Pipeline:
- PIPE_STAGES=1: all encoding is combinational into the output register; latency 1.
- PIPE_STAGES=2:
  - Stage 1 registers q_m, N1-N0 and mode/cd/aux.
  - Stage 2 performs the disparity decision, tmds_o, the cnt update and mode_err_o; latency 2.
- Back-to-back mode changes on consecutive cycles are legal. Each symbol uses the cnt value left by the immediately preceding symbol; there is no bubble.

Decomposition:
- Package tmds_pkg holds:
  - tmds_mode_e
  - the CTRL code array[4]
  - constants GB_VIDEO_02=1011001100, GB_VIDEO_1=0100110011 and GB_ISLAND_12=0100110011
  - function terc4(logic [3:0]) -> logic [9:0], per HDMI 1.4 Table 5-4; for example 0000->1010011100, 1101->1001110001, 1111->1011000011
- Sub-module tmds_qm_stage: combinational vd_i -> {q_m[8:0], signed N1-N0}. The top level registers it or not according to PIPE_STAGES.

Test Plan:
- Disparity from 0, PIPE_STAGES=1: VIDEO with vd_i=0x00 for two cycles.
  - tmds_o = 0100000000 with disp_o=-8.
  - Then tmds_o = 1111111111 with disp_o=+2.
- CTRL: cd_i=2'b11 after a VIDEO run -> tmds_o=1010101011 one cycle later; disp_o=0.
- Video guard band: VIDEO_GB -> tmds_o=1011001100 for CHANNEL=0 and 0100110011 for CHANNEL=1.
- Data island:
  - ISLAND with aux_i=4'h0 -> tmds_o=1010011100.
  - ISLAND with aux_i=4'hF -> tmds_o=1011000011.
  - ISLAND_GB with CHANNEL=0, cd_i=01 -> tmds_o=1001110001.
- Reserved mode: mode_i=7, cd_i=00 -> tmds_o=1101010100 and mode_err_o=1 for exactly one cycle; disp_o=0.
- PIPE_STAGES=2 and reset:
  - The first vector's output appears 2 cycles later.
  - Asserting rstn_i mid-VIDEO forces tmds_o=0 and disp_o=0 asynchronously.
  - After release, the first 0x00 pixel yields 0100000000 again.
